frame_buffer_pingpong: RTL and testbench



---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_bank_ram.sv | 29 ++
 rtl/frame_buffer_pingpong.sv | 189 ++++++++++++++++++
 tb/tb_frame_buffer_pingpong.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the ping-pong frame buffer.
package fb_pkg;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } fb_state_e;

  localparam int FB_H_RES      = 160;
  localparam int FB_V_RES      = 144;
  localparam int FB_PIX_W      = 2;
  localparam int FB_FRAME_SIZE = FB_H_RES * FB_V_RES;

  function automatic int fb_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Single-clock pixel RAM: one write port, one registered read port, contents not reset.
module fb_bank_ram
  import fb_pkg::*;
#(
  parameter int PIX_W  = FB_PIX_W,
  parameter int DEPTH  = FB_FRAME_SIZE,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [PIX_W-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [PIX_W-1:0]  o_rdata
);

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rdata;

  // Read-before-write: a same-address read in the write cycle returns the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered raster frame store; banks swap only in reader blanking.
// FB_DOUBLE_BUFFER_EN selects two banks + PENDING handover; otherwise a single live bank.
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter int PIX_W  = FB_PIX_W,
  parameter int H_RES  = FB_H_RES,
  parameter int V_RES  = FB_V_RES,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic              wr_sof,
  input  logic [PIX_W-1:0]  wr_pix,
  output logic              wr_ready,
  output logic              frame_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_pix,
  input  logic              rd_swap,
  output logic              swap_ack,
  output logic              rd_bank
);

  localparam int FRAME = H_RES * V_RES;
  localparam int XW    = fb_cnt_w(H_RES);
  localparam int YW    = fb_cnt_w(V_RES);
  localparam logic [XW-1:0]   X_LAST  = XW'(H_RES - 1);
  localparam logic [YW-1:0]   Y_LAST  = YW'(V_RES - 1);
  localparam logic [ADDR_W:0] FRAME_A = (ADDR_W + 1)'(FRAME);

  logic [XW-1:0]     r_x_cnt;
  logic [YW-1:0]     r_y_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_frame_done;
  logic              r_rd_seen;
  logic              r_rd_oob;

  logic              w_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_oob;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_accept  = wr_valid & w_ready;
  assign w_last    = ~wr_sof & (r_x_cnt == X_LAST) & (r_y_cnt == Y_LAST);
  assign w_wr_addr = wr_sof ? '0 : r_wr_addr;
  assign w_oob     = ({1'b0, rd_addr} >= FRAME_A);

  // r_wr_addr mirrors y_cnt*H_RES + x_cnt without a multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_wr_addr    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept & w_last;
      if (w_accept) begin
        if (wr_sof) begin
          r_x_cnt   <= XW'(1);
          r_y_cnt   <= '0;
          r_wr_addr <= ADDR_W'(1);
        end else if (r_x_cnt == X_LAST) begin
          r_x_cnt <= '0;
          if (r_y_cnt == Y_LAST) begin
            r_y_cnt   <= '0;
            r_wr_addr <= '0;
          end else begin
            r_y_cnt   <= r_y_cnt + 1'b1;
            r_wr_addr <= r_wr_addr + 1'b1;
          end
        end else begin
          r_x_cnt   <= r_x_cnt + 1'b1;
          r_wr_addr <= r_wr_addr + 1'b1;
        end
      end
    end
  end

  // Out-of-range reads are masked to zero on the output instead of touching the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_seen <= 1'b0;
      r_rd_oob  <= 1'b0;
    end else if (rd_en) begin
      r_rd_seen <= 1'b1;
      r_rd_oob  <= w_oob;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN

  fb_state_e        r_state;
  fb_state_e        w_state_nxt;
  logic             r_rd_bank;
  logic             r_rd_sel;
  logic             r_swap_ack;
  logic             w_do_swap;
  logic [PIX_W-1:0] w_q_a;
  logic [PIX_W-1:0] w_q_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_rd_bank  <= 1'b1;
      r_swap_ack <= 1'b0;
      r_rd_sel   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_bank  <= r_rd_bank ^ w_do_swap;
      r_swap_ack <= w_do_swap;
      if (rd_en) r_rd_sel <= r_rd_bank;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_do_swap   = 1'b0;
    case (r_state)
      FILL: begin
        w_ready = 1'b1;
        if (wr_valid && w_last) w_state_nxt = PENDING;
      end
      PENDING: begin
        if (rd_swap) begin
          w_do_swap   = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Bank A is written while the reader owns bank B (rd_bank=1), and vice versa.
  fb_bank_ram #(.PIX_W(PIX_W), .DEPTH(FRAME), .ADDR_W(ADDR_W)) u_bank_a (
    .clk     (clk),
    .i_we    (w_accept & r_rd_bank),
    .i_waddr (w_wr_addr),
    .i_wdata (wr_pix),
    .i_re    (rd_en & ~w_oob & ~r_rd_bank),
    .i_raddr (rd_addr),
    .o_rdata (w_q_a)
  );

  fb_bank_ram #(.PIX_W(PIX_W), .DEPTH(FRAME), .ADDR_W(ADDR_W)) u_bank_b (
    .clk     (clk),
    .i_we    (w_accept & ~r_rd_bank),
    .i_waddr (w_wr_addr),
    .i_wdata (wr_pix),
    .i_re    (rd_en & ~w_oob & r_rd_bank),
    .i_raddr (rd_addr),
    .o_rdata (w_q_b)
  );

  assign rd_pix   = (r_rd_seen & ~r_rd_oob) ? (r_rd_sel ? w_q_b : w_q_a) : '0;
  assign swap_ack = r_swap_ack;
  assign rd_bank  = r_rd_bank;

`else

  logic [PIX_W-1:0] w_q_live;
  logic             w_unused_swap;

  assign w_ready       = 1'b1;
  assign w_unused_swap = rd_swap;

  fb_bank_ram #(.PIX_W(PIX_W), .DEPTH(FRAME), .ADDR_W(ADDR_W)) u_bank_live (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (w_wr_addr),
    .i_wdata (wr_pix),
    .i_re    (rd_en & ~w_oob),
    .i_raddr (rd_addr),
    .o_rdata (w_q_live)
  );

  assign rd_pix   = (r_rd_seen & ~r_rd_oob) ? w_q_live : '0;
  assign swap_ack = 1'b0;
  assign rd_bank  = 1'b0;

`endif

  assign wr_ready   = w_ready;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed + randomized bench for frame_buffer_pingpong against a linear-index frame model.
module tb_frame_buffer_pingpong;

  localparam int PIX_W  = 2;
  localparam int H_RES  = 20;
  localparam int V_RES  = 12;
  localparam int ADDR_W = 8;
  localparam int FRAME  = H_RES * V_RES;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_sof;
  logic [PIX_W-1:0]  wr_pix;
  logic              wr_ready;
  logic              frame_done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_pix;
  logic              rd_swap;
  logic              swap_ack;
  logic              rd_bank;

  always #5 clk = ~clk;

  frame_buffer_pingpong #(.PIX_W(PIX_W), .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_sof     (wr_sof),
    .wr_pix     (wr_pix),
    .wr_ready   (wr_ready),
    .frame_done (frame_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_pix     (rd_pix),
    .rd_swap    (rd_swap),
    .swap_ack   (swap_ack),
    .rd_bank    (rd_bank)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: two arrays of pixels, a linear "pixels accepted this frame" index, a pending flag.
  int mem   [2][FRAME];
  bit known [2][FRAME];
  int m_n;
  bit m_pend;
  int m_rd_bank;
  int exp_rd;
  bit exp_rd_known;
  int exp_fd;
  int exp_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n          = 0;
    m_pend       = 1'b0;
    m_rd_bank    = DBL ? 1 : 0;
    exp_rd       = 0;
    exp_rd_known = 1'b1;
    exp_fd       = 0;
    exp_ack      = 0;
  endtask

  task automatic check_outputs(input string ctx);
    if (exp_rd_known) chk({ctx, "_rd_pix"}, rd_pix, exp_rd);
    chk({ctx, "_frame_done"}, frame_done, exp_fd);
    chk({ctx, "_swap_ack"}, swap_ack, exp_ack);
    chk({ctx, "_rd_bank"}, rd_bank, m_rd_bank);
    chk({ctx, "_wr_ready"}, wr_ready, (DBL && m_pend) ? 0 : 1);
  endtask

  // Apply one clock edge with the inputs currently driven, updating the model alongside.
  task automatic tick();
    bit acc;
    bit pend_before;
    int wb;
    int idx;
    chk("wr_ready_pre", wr_ready, (DBL && m_pend) ? 0 : 1);
    pend_before = m_pend;
    acc         = wr_valid && !m_pend;
    exp_fd      = 0;
    exp_ack     = 0;
    wb          = DBL ? 1 - m_rd_bank : 0;
    if (rd_en) begin
      if (int'(rd_addr) >= FRAME) begin
        exp_rd       = 0;
        exp_rd_known = 1'b1;
      end else begin
        exp_rd       = mem[m_rd_bank][rd_addr];
        exp_rd_known = known[m_rd_bank][rd_addr];
      end
    end
    if (acc) begin
      idx              = wr_sof ? 0 : m_n;
      mem[wb][idx]     = int'(wr_pix);
      known[wb][idx]   = 1'b1;
      if (wr_sof) m_n = 1;
      else if (m_n == FRAME - 1) begin
        m_n    = 0;
        exp_fd = 1;
        if (DBL) m_pend = 1'b1;
      end else m_n++;
    end
    if (DBL && pend_before && rd_swap) begin
      m_rd_bank = 1 - m_rd_bank;
      exp_ack   = 1;
      m_pend    = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  initial begin
    int cnt;
    int sv;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < FRAME; a++) begin
        mem[b][a]   = 0;
        known[b][a] = 1'b0;
      end
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    wr_pix   = '0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    rd_swap  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_rd_pix", rd_pix, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_rd_bank", rd_bank, DBL ? 1 : 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst_n = 1'b1;

    // Frame 1: pixel i carries i%4, reads scattered over the reader's bank.
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      wr_valid = 1'b1;
      wr_sof   = (i == 0);
      wr_pix   = PIX_W'(i % 4);
      rd_en    = 1'($urandom % 2);
      rd_addr  = ADDR_W'($urandom_range(0, FRAME - 1));
      tick();
      cnt += int'(frame_done);
    end
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    rd_en    = 1'b0;
    chk("frame1_done_now", frame_done, 1);
    tick();
    cnt += int'(frame_done);
    chk("frame1_done_pulses", cnt, 1);
    chk("frame1_ready_after", wr_ready, DBL ? 0 : 1);

    wr_valid = 1'b1;
    repeat (3) begin
      wr_pix = PIX_W'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    rd_swap  = 1'b1;
    tick();
    rd_swap = 1'b0;
    chk("swap_ack_pulse", swap_ack, DBL ? 1 : 0);
    chk("swap_rd_bank", rd_bank, 0);
    tick();
    chk("swap_ack_single", swap_ack, 0);

    rd_en   = 1'b1;
    rd_addr = ADDR_W'(5);
    tick();
    chk("rd_addr5", rd_pix, 1);
    rd_addr = ADDR_W'(H_RES - 1);
    tick();
    chk("rd_line_end", rd_pix, (H_RES - 1) % 4);
    rd_en = 1'b0;

    // Restart mid-frame with wr_sof, and hold rd_swap over the end of that frame.
    cnt      = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_pix = PIX_W'($urandom);
      tick();
      cnt += int'(frame_done);
    end
    sv     = int'($urandom_range(1, 3));
    wr_sof = 1'b1;
    wr_pix = PIX_W'(sv);
    tick();
    cnt += int'(frame_done);
    wr_sof = 1'b0;
    for (int i = 1; i < FRAME - 1; i++) begin
      wr_pix  = PIX_W'($urandom);
      rd_swap = (i >= FRAME - 6);
      tick();
      cnt += int'(frame_done);
    end
    chk("sof_no_early_done", cnt, 0);
    wr_pix = PIX_W'($urandom);
    tick();
    chk("sof_frame_done", frame_done, 1);
    chk("held_ready_low", wr_ready, DBL ? 0 : 1);
    wr_valid = 1'b0;
    tick();
    chk("held_swap_ack", swap_ack, DBL ? 1 : 0);
    chk("held_ready_back", wr_ready, 1);
    rd_swap = 1'b0;

    rd_en   = 1'b1;
    rd_addr = '0;
    tick();
    chk("sof_pix_at_0", rd_pix, sv);
    rd_addr = ADDR_W'(FRAME);
    tick();
    chk("oob_zero", rd_pix, 0);
    rd_addr = '0;
    tick();
    rd_en   = 1'b0;
    rd_addr = ADDR_W'(FRAME);
    tick();
    chk("hold_oob_addr", rd_pix, sv);
    rd_addr = ADDR_W'($urandom);
    tick();
    chk("hold_again", rd_pix, sv);

    // Random traffic across several frame boundaries and swaps.
    for (int i = 0; i < 900; i++) begin
      wr_valid = ($urandom % 4) != 0;
      wr_sof   = ($urandom % 64) == 0;
      wr_pix   = PIX_W'($urandom);
      rd_en    = 1'($urandom % 2);
      rd_addr  = ADDR_W'($urandom);
      rd_swap  = ($urandom % 8) == 0;
      tick();
    end

    // Drive into PENDING (or mid-frame without double buffering), then reset asynchronously.
    wr_sof   = 1'b0;
    rd_swap  = 1'b0;
    rd_en    = 1'b1;
    rd_addr  = '0;
    wr_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      if (DBL ? m_pend : (m_n == FRAME / 2)) break;
      wr_pix = PIX_W'($urandom);
      tick();
    end
    chk("pre_reset_ready", wr_ready, DBL ? 0 : 1);
    wr_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_rd_pix", rd_pix, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_swap_ack", swap_ack, 0);
    chk("arst_rd_bank", rd_bank, DBL ? 1 : 0);
    chk("arst_wr_ready", wr_ready, 1);
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cnt      = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      wr_pix = PIX_W'($urandom);
      tick();
      cnt += int'(frame_done);
    end
    chk("post_reset_done_at_end", frame_done, 1);
    chk("post_reset_no_early_done", cnt, 1);
    wr_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
